// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory MMIO responder: register offsets,
// STATUS bit layout and the default MMIO page.
package mmio_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h1;
  localparam logic [3:0] OFF_CYCLE   = 4'h2;
  localparam logic [3:0] OFF_SCRATCH = 4'h3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [7:0] MMIO_PAGE_DEFAULT = 8'hFF;

  function automatic logic [31:0] status_word(input logic [4:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[ST_COUNT_LSB +: 5] = count;
    w[ST_OVF]            = ovf;
    w[ST_FULL]           = full;
    w[ST_EMPTY]          = empty;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_fifo.sv
// Synchronous FIFO with drop-on-full push and a valid/ready head.
// Storage is cleared on reset so the head reads zero afterwards.
module mmio_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_DEPTH);
  assign empty = (count_q == {CW{1'b0}});
  assign valid = ~empty;
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = ready & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: passes ordinary accesses to dmem and decodes
// the top 16 words as TX FIFO, STATUS, CYCLE counter and SCRATCH registers.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        stb,
  output logic [31:0] q_dmem,
  input  logic [31:0] dmem_q,
  output logic        dmem_wren,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [3:0]    offset;
  logic          wr_hit;
  logic          push;
  logic          ovf_clr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic [CW-1:0] fifo_count;
  logic [4:0]    status_count;
  logic [31:0]   rd_val;

  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   scratch_q, scratch_d;
  logic          overflow_q, overflow_d;
  logic          sel_q, sel_d;
  logic [31:0]   mmio_q, mmio_d;

  mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (data),
    .ready     (tx_ready),
    .head      (tx_data),
    .valid     (tx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Only the stb cycle of a store may cause a side effect; reads never do.
  always_comb begin
    hit          = (address_dmem[11:4] == MMIO_PAGE);
    offset       = address_dmem[3:0];
    wr_hit       = stb & wren & hit;
    dmem_wren    = wren & ~hit;
    push         = wr_hit & (offset == OFF_TXDATA);
    ovf_clr      = wr_hit & (offset == OFF_STATUS) & data[ST_OVF];
    status_count = 5'(fifo_count);

    if (wr_hit && (offset == OFF_CYCLE)) begin
      cycle_d = data;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end

    if (wr_hit && (offset == OFF_SCRATCH)) begin
      scratch_d = data;
    end else begin
      scratch_d = scratch_q;
    end

    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    case (offset)
      OFF_STATUS:  rd_val = status_word(status_count, overflow_q, fifo_full, fifo_empty);
      OFF_CYCLE:   rd_val = cycle_q;
      OFF_SCRATCH: rd_val = scratch_q;
      default:     rd_val = 32'h0000_0000;
    endcase

    sel_d  = hit;
    mmio_d = rd_val;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q    <= 32'h0000_0000;
      scratch_q  <= 32'h0000_0000;
      overflow_q <= 1'b0;
      sel_q      <= 1'b0;
      mmio_q     <= 32'h0000_0000;
    end else begin
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      overflow_q <= overflow_d;
      sel_q      <= sel_d;
      mmio_q     <= mmio_d;
    end
  end

  // Same one-cycle latency as the dmem syncram, so the processor sees no difference.
  assign q_dmem = sel_q ? mmio_q : dmem_q;

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder on the processor's data-memory port. It sits between the processor's `address_dmem`/`data`/`wren`/`q_dmem` bus and the `dmem` syncram. Word addresses 0xFF0–0xFFF are decoded as memory-mapped registers: a TX FIFO, a status word, a cycle counter and a scratch register. All other addresses pass through to `dmem` unchanged. The TX FIFO drains through a valid/ready stream port toward an off-chip consumer.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, at least 2.
- `MMIO_PAGE`, 8'hFF: value of `address_dmem[11:4]` that selects the MMIO region.

Ports:
- `clock` in 1: single clock, the same edge as `dmem_clock`.
- `reset` in 1: asynchronous, active-high.
- `address_dmem` in 12: processor word address.
- `data` in 32: processor store data.
- `wren` in 1: processor store request.
- `stb` in 1: one-`clock` pulse marking the first cycle of each processor access. It qualifies all side effects.
- `q_dmem` out 32: read data returned to the processor.
- `dmem_q` in 32: `q` from `dmem`.
- `dmem_wren` out 1: gated write enable to `dmem`.
- `tx_data` out 32: FIFO head.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts the head this cycle.

## Operation
- Decode: `hit = (address_dmem[11:4] == MMIO_PAGE)`.
- `dmem_wren = wren & ~hit`. This is combinational; `dmem` never sees MMIO stores.
- Register map (offset = `address_dmem[3:0]`):
  - 0x0 TXDATA: a write pushes `data`. A read returns 0.
  - 0x1 STATUS: read returns `{19'b0, count[4:0], 5'b0, overflow, full, empty}`. Writing bit 2 = 1 clears `overflow`. Other bits are ignored.
  - 0x2 CYCLE: reads the free-running 32-bit counter. A write loads `data` into it.
  - 0x3 SCRATCH: plain read/write register.
  - 0x4–0xF: reads return 0; writes are ignored.
- A write side effect occurs only when `stb & wren & hit`. Reads are side-effect free, so holding the address for several `clock` cycles (processor clock is `clock`/4) is harmless.
- CYCLE increments by 1 every `clock` and wraps from 0xFFFFFFFF to 0. A write in the same cycle wins: the loaded value is `data`, with no increment that cycle.
- FIFO:
  - Push when full and not popping: the data is dropped and `overflow` sets (sticky).
  - Push and pop in the same cycle when full: both happen, `count` is unchanged, and `overflow` is not set.
  - Pop when `tx_valid & tx_ready`.
  - Pop when empty: no effect.
  - `count` has range 0..`FIFO_DEPTH`. Pointers wrap modulo `FIFO_DEPTH`.
- `overflow` set and clear in the same cycle cannot occur, because only one address is written per cycle.

## Timing
- Read latency is 1 `clock`, matching the `dmem` syncram.
  - On each rising edge, register `sel_q <= hit` and `mmio_q <=` the selected register value (pre-edge state).
  - `q_dmem = sel_q ? mmio_q : dmem_q`.
- A STATUS or CYCLE read in the same cycle as a push or increment returns the pre-edge value.
- `tx_valid` and `tx_data` are registered FIFO state.
  - A word pushed at edge N is visible at N+1.
  - A pop at edge N exposes the next head at N+1.
- Reset values (asynchronous, immediate):
  - `count`, `overflow`, CYCLE, SCRATCH, pointers, `sel_q` and `mmio_q` are all 0.
  - FIFO storage is cleared, so `tx_valid` = 0 and `tx_data` = 0.
  - `q_dmem` follows `dmem_q`.
  - `dmem_wren` stays combinational.
- Reset mid-stream: FIFO contents are discarded and any in-flight `tx_ready` handshake is void. The first handshake after reset is possible one cycle after deassertion, and only once a new push has occurred.

## Structure
- Package `mmio_pkg`:
  - Register offset constants (TXDATA=0, STATUS=1, CYCLE=2, SCRATCH=3).
  - STATUS bit positions (EMPTY=0, FULL=1, OVF=2, COUNT_LSB=8).
  - Default `MMIO_PAGE`.
- Sub-module `mmio_fifo`: a synchronous FIFO with push/pop, full/empty/count and drop-on-full. It is parameterised by depth and width, and is reusable for a later RX path.
- The top level holds decode, CYCLE, SCRATCH, `overflow`, and the read mux and register.

## Test plan
- Reset, then read 0xFF1 → `q_dmem` = 0x00000001. Read 0xFF2 after 10 clocks → value in 9..11 (one-cycle read latency).
- Store 0xDEADBEEF to 0x010 with `stb`: `dmem_wren` = 1 for that cycle, and a read of 0x010 returns 0xDEADBEEF. Store to 0xFF3: `dmem_wren` stays 0, and a read of 0xFF3 returns the stored value.
- With `tx_ready` = 0, push 0x41, 0x42, 0x43 → STATUS count = 3 and `tx_data` = 0x41. Then raise `tx_ready` for 3 cycles → 0x41, 0x42, 0x43 handed off in order, and `tx_valid` = 0 afterwards.
- Push 17 words with `tx_ready` = 0 → STATUS = 0x00001006 (count 16, full, overflow). The 17th word is absent on drain. Write 0x4 to STATUS → `overflow` clears.
- FIFO full, push 0x99 while `tx_ready` = 1 in the same cycle → count stays 16, overflow = 0, and 0x99 is the last word drained.
- Write 0xFFFFFFFE to CYCLE, wait 3 clocks, read → wrap observed (value 1 ± read latency). Assert `reset` mid-drain → `tx_valid` drops immediately and count reads 0.
